// File: rtl/mul_result_accumulator.sv
// ---------------------------------------------------------------------------
// mul_result_accumulator
//
// Downstream reduction stage for the 8x8 custom multiplier. Registered
// products arrive under a valid/ready handshake. COUNT consecutive products
// are summed into one frame result, which is held under valid/ready until the
// consumer takes it. A new frame can start in the same cycle that the
// previous result is taken, so back-to-back frames have no bubble.
//
// Configuration macro:
//   ACC_SATURATE_EN  defined   : on carry out the accumulator clamps to all
//                                ones for the rest of the frame.
//                    undefined : the accumulator wraps modulo 2^ACC_W.
//   Both builds set the sticky overflow flag on a carry out.
//
// Parameters:
//   DATA_W  product width (must match the multiplier output)
//   ACC_W   accumulator / result width, ACC_W >= DATA_W
//   COUNT   products per frame, >= 1
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   init       synchronous frame clear, active-high (shared with multiplier)
//   in_valid   in_data carries a product
//   in_data    product from the multiplier
//   in_ready   stage accepts in_data this cycle
//   out_valid  out_data holds a completed frame sum
//   out_data   frame sum (zero when out_valid is low)
//   out_ready  consumer takes out_data this cycle
//   overflow   current/last frame exceeded ACC_W; sticky per frame
// ---------------------------------------------------------------------------
module mul_result_accumulator #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int COUNT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_data,
  input  logic              out_ready,
  output logic              overflow
);

  localparam int CNT_W = $clog2(COUNT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf;
  logic               vld;

  logic               accept;
  logic               xfer;
  logic [ACC_W-1:0]   in_ext;
  logic [ACC_W:0]     add_res;

  // One accumulation step: returns {carry, next_acc}. The carry is the bit
  // above the accumulator; in the saturating build it also forces the clamp.
  function automatic logic [ACC_W:0] acc_step(input logic [ACC_W-1:0] a,
                                              input logic [ACC_W-1:0] b);
    logic [ACC_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
`ifdef ACC_SATURATE_EN
    if (sum[ACC_W]) begin
      sum[ACC_W-1:0] = {ACC_W{1'b1}};
    end
`endif
    return sum;
  endfunction

  assign in_ext  = ACC_W'(in_data);
  assign add_res = acc_step(acc, in_ext);

  // in_ready is the only combinational path from out_ready; it is forced low
  // whenever a clear is in progress so no product is consumed by a dying frame.
  always_comb begin
    in_ready = 1'b0;
    if (!rst && !init) begin
      case (state)
        IDLE, ACCUM: in_ready = 1'b1;
        HOLD:        in_ready = out_ready;
        default:     in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid & in_ready;
  assign xfer   = vld & out_ready;

  always_ff @(posedge clk) begin
    if (rst || init) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      vld   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc <= in_ext;
            cnt <= CNT_W'(1);
            ovf <= 1'b0;
            if (COUNT == 1) begin
              state <= HOLD;
              vld   <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc <= add_res[ACC_W-1:0];
            cnt <= cnt + CNT_W'(1);
            if (add_res[ACC_W]) ovf <= 1'b1;
            if (cnt == CNT_W'(COUNT - 1)) begin
              state <= HOLD;
              vld   <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (xfer) begin
            if (accept) begin
              // Result leaves and the next frame's first product lands in the
              // same edge: no idle cycle between frames.
              acc <= in_ext;
              cnt <= CNT_W'(1);
              ovf <= 1'b0;
              if (COUNT == 1) begin
                state <= HOLD;
                vld   <= 1'b1;
              end else begin
                state <= ACCUM;
                vld   <= 1'b0;
              end
            end else begin
              state <= IDLE;
              vld   <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          vld   <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = vld;
  assign out_data  = vld ? acc : '0;
  assign overflow  = ovf;

endmodule

// File: tb/tb_mul_result_accumulator.sv
// ---------------------------------------------------------------------------
// tb_mul_result_accumulator
//
// Drives two instances with identical stimulus: one with default parameters
// (ACC_W=16) and one with ACC_W=9 so that overflow behaviour is reachable with
// 8-bit products. Directed scenarios are followed by a randomized run checked
// against a frame-level reference model (raw sums folded to the accumulator
// width only when the result is reported).
// ---------------------------------------------------------------------------
module tb_mul_result_accumulator;

  localparam int DATA_W = 8;
  localparam int COUNT  = 4;
  localparam int ACC_A  = 16;
  localparam int ACC_B  = 9;

  logic              clk;
  logic              rst;
  logic              init;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_ready;

  logic              a_in_ready, a_out_valid, a_overflow;
  logic [ACC_A-1:0]  a_out_data;
  logic              b_in_ready, b_out_valid, b_overflow;
  logic [ACC_B-1:0]  b_out_data;

  int n_checks = 0;
  int n_fail   = 0;

  mul_result_accumulator #(.DATA_W(DATA_W), .ACC_W(ACC_A), .COUNT(COUNT)) dut (
    .clk(clk), .rst(rst), .init(init),
    .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(out_ready),
    .overflow(a_overflow)
  );

  mul_result_accumulator #(.DATA_W(DATA_W), .ACC_W(ACC_B), .COUNT(COUNT)) dut9 (
    .clk(clk), .rst(rst), .init(init),
    .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(out_ready),
    .overflow(b_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs away from the active edge; outputs are then
  // settled for the current (pre-edge) state and can be compared.
  task automatic cyc(input logic v, input logic [7:0] d, input logic ordy,
                     input logic ini, input logic r);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    init      = ini;
    rst       = r;
    #1;
  endtask

  // Feed one full frame of four products, one per cycle, consumer ready.
  task automatic frame(input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3);
    cyc(1, d0, 1, 0, 0);
    cyc(1, d1, 1, 0, 0);
    cyc(1, d2, 1, 0, 0);
    cyc(1, d3, 1, 0, 0);
  endtask

  // Expected stored result for a raw frame sum in an accumulator of width w.
  function automatic longint fold(input longint s, input int w);
    longint maxv;
    maxv = (longint'(1) << w) - 1;
`ifdef ACC_SATURATE_EN
    return (s > maxv) ? maxv : s;
`else
    return s & maxv;
`endif
  endfunction

  task automatic test_reset();
    cyc(0, 0, 0, 0, 1);
    cyc(1, 8'd55, 1, 0, 1);
    n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", a_in_ready); end
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); end
    n_checks++; if (a_out_data !== 16'd0) begin n_fail++; $display("FAIL reset_out_data: got %0d expected 0", a_out_data); end
    n_checks++; if (a_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", a_overflow); end
    cyc(0, 0, 1, 0, 0);
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", a_in_ready); end
  endtask

  task automatic test_basic();
    frame(8'd10, 8'd20, 8'd30, 8'd40);
    cyc(0, 0, 1, 0, 0);
    n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", a_out_valid); end
    n_checks++; if (a_out_data !== 16'd100) begin n_fail++; $display("FAIL basic_data: got %0d expected 100", a_out_data); end
    n_checks++; if (a_overflow !== 1'b0) begin n_fail++; $display("FAIL basic_overflow: got %b expected 0", a_overflow); end
    cyc(0, 0, 1, 0, 0);
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop: got %b expected 0", a_out_valid); end
    n_checks++; if (a_out_data !== 16'd0) begin n_fail++; $display("FAIL basic_data_zero: got %0d expected 0", a_out_data); end
  endtask

  task automatic test_backpressure();
    frame(8'd10, 8'd20, 8'd30, 8'd40);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 8'd99, 0, 0, 0);
      n_checks++; if (a_out_data !== 16'd100 || a_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold: cycle %0d got valid=%b data=%0d expected valid=1 data=100", i, a_out_valid, a_out_data); end
      n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: cycle %0d got %b expected 0", i, a_in_ready); end
    end
    cyc(0, 0, 1, 0, 0);
    n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_take: got %b expected 1", a_out_valid); end
    cyc(0, 0, 1, 0, 0);
    n_checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle: got valid=%b ready=%b expected valid=0 ready=1", a_out_valid, a_in_ready); end
    // The ignored 99s must not have leaked into the next frame.
    frame(8'd1, 8'd1, 8'd1, 8'd1);
    cyc(0, 0, 1, 0, 0);
    n_checks++; if (a_out_data !== 16'd4) begin n_fail++; $display("FAIL bp_next_frame: got %0d expected 4", a_out_data); end
  endtask

  task automatic test_overflow();
    longint exp9;
`ifdef ACC_SATURATE_EN
    exp9 = 511;
`else
    exp9 = 508;
`endif
    frame(8'd255, 8'd255, 8'd255, 8'd255);
    cyc(0, 0, 0, 0, 0);
    n_checks++; if (longint'(b_out_data) != exp9) begin n_fail++; $display("FAIL ovf_data9: got %0d expected %0d", b_out_data, exp9); end
    n_checks++; if (b_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag9: got %b expected 1", b_overflow); end
    n_checks++; if (a_out_data !== 16'd1020 || a_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_wide: got data=%0d ovf=%b expected data=1020 ovf=0", a_out_data, a_overflow); end
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    n_checks++; if (b_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky_idle: got %b expected 1", b_overflow); end
    cyc(1, 8'd1, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    n_checks++; if (b_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear_first_accept: got %b expected 0", b_overflow); end
    cyc(0, 0, 1, 1, 0);
  endtask

  task automatic test_init();
    cyc(1, 8'd5, 1, 0, 0);
    cyc(1, 8'd6, 1, 0, 0);
    cyc(1, 8'd9, 1, 1, 0);
    n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL init_in_ready: got %b expected 0", a_in_ready); end
    frame(8'd1, 8'd2, 8'd3, 8'd4);
    cyc(0, 0, 0, 0, 0);
    n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== 16'd10) begin n_fail++; $display("FAIL init_discard: got valid=%b data=%0d expected valid=1 data=10", a_out_valid, a_out_data); end
    cyc(0, 0, 1, 0, 0);
  endtask

  task automatic test_back_to_back();
    frame(8'd10, 8'd20, 8'd30, 8'd40);
    cyc(1, 8'd7, 1, 0, 0);
    n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== 16'd100 || a_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_first: got valid=%b data=%0d ready=%b expected 1/100/1", a_out_valid, a_out_data, a_in_ready); end
    cyc(1, 8'd1, 1, 0, 0);
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_accum: got %b expected 0", a_out_valid); end
    cyc(1, 8'd1, 1, 0, 0);
    cyc(1, 8'd1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== 16'd10) begin n_fail++; $display("FAIL b2b_second: got valid=%b data=%0d expected valid=1 data=10", a_out_valid, a_out_data); end
    cyc(0, 0, 1, 0, 0);
  endtask

  task automatic test_rst_in_hold();
    frame(8'd255, 8'd255, 8'd255, 8'd255);
    cyc(0, 0, 0, 0, 0);
    n_checks++; if (b_out_valid !== 1'b1 || b_overflow !== 1'b1) begin n_fail++; $display("FAIL rst_pre_hold: got valid=%b ovf=%b expected 1/1", b_out_valid, b_overflow); end
    cyc(1, 8'd3, 1, 0, 1);
    n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_hold_ready: got %b expected 0", a_in_ready); end
    cyc(0, 0, 0, 0, 0);
    n_checks++; if (b_out_valid !== 1'b0 || b_out_data !== 9'd0 || b_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_hold_clear: got valid=%b data=%0d ovf=%b expected 0/0/0", b_out_valid, b_out_data, b_overflow); end
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_hold_idle_ready: got %b expected 1", a_in_ready); end
  endtask

  task automatic test_random();
    bit     holding;
    int     cnt;
    longint psum, held, last;
    logic   v, ordy, ini, exp_rdy;
    logic [7:0] d;
    longint exp_a, exp_b;
    logic   eo_a, eo_b;
    longint max_a, max_b;
    max_a = (longint'(1) << ACC_A) - 1;
    max_b = (longint'(1) << ACC_B) - 1;
    cyc(0, 0, 1, 1, 0);
    holding = 0; cnt = 0; psum = 0; held = 0; last = 0;
    for (int i = 0; i < 400; i++) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      ini  = ($urandom_range(0, 39) == 0);
      d    = 8'($urandom_range(0, 255));
      cyc(v, d, ordy, ini, 0);
      exp_rdy = ini ? 1'b0 : (holding ? ordy : 1'b1);
      exp_a = holding ? fold(held, ACC_A) : 0;
      exp_b = holding ? fold(held, ACC_B) : 0;
      if (holding) begin
        eo_a = held > max_a; eo_b = held > max_b;
      end else if (cnt > 0) begin
        eo_a = psum > max_a; eo_b = psum > max_b;
      end else begin
        eo_a = last > max_a; eo_b = last > max_b;
      end
      n_checks++; if (a_in_ready !== exp_rdy || b_in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_in_ready: cycle %0d got %b/%b expected %b", i, a_in_ready, b_in_ready, exp_rdy); end
      n_checks++; if (a_out_valid !== logic'(holding) || b_out_valid !== logic'(holding)) begin n_fail++; $display("FAIL rnd_out_valid: cycle %0d got %b/%b expected %b", i, a_out_valid, b_out_valid, holding); end
      n_checks++; if (longint'(a_out_data) != exp_a) begin n_fail++; $display("FAIL rnd_data16: cycle %0d got %0d expected %0d", i, a_out_data, exp_a); end
      n_checks++; if (longint'(b_out_data) != exp_b) begin n_fail++; $display("FAIL rnd_data9: cycle %0d got %0d expected %0d", i, b_out_data, exp_b); end
      n_checks++; if (a_overflow !== eo_a || b_overflow !== eo_b) begin n_fail++; $display("FAIL rnd_overflow: cycle %0d got %b/%b expected %b/%b", i, a_overflow, b_overflow, eo_a, eo_b); end
      // Advance the frame-level model across the coming clock edge.
      if (ini) begin
        holding = 0; cnt = 0; psum = 0; held = 0; last = 0;
      end else begin
        if (holding && ordy) begin
          holding = 0;
          last = held;
        end
        if (v && exp_rdy) begin
          psum = (cnt == 0) ? longint'(d) : psum + longint'(d);
          cnt++;
          if (cnt == COUNT) begin
            holding = 1; held = psum; cnt = 0; psum = 0;
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; init = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_init();
    test_back_to_back();
    test_rst_in_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
